// File: rtl/sha256_round_controller_pkg.sv
// Shared definitions for the SHA-256 round controller: FSM encoding, sizing
// parameters, and the round-constant and initial-hash tables used by the datapath.
package sha256_pkg;

    localparam int unsigned NUM_ROUNDS  = 64;
    localparam int unsigned SCHED_WORDS = 16;
    localparam int unsigned IDX_W       = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_UPDATE,
        ST_DONE
    } state_e;

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [0:7][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/sha256_round_controller_if.sv
// Block handshake, scheduler control and datapath strobes of the round controller.
interface sha256_round_controller_if
    import sha256_pkg::*;
();
    logic             blk_valid;
    logic             blk_ready;
    logic             blk_first;
    logic             blk_last;
    logic             abort;
    logic             sched_init;
    logic [IDX_W-1:0] sched_index;
    logic             round_en;
    logic             wv_load;
    logic             iv_sel;
    logic             digest_update;
    logic             digest_valid;
    logic             digest_ready;
    logic             busy;

    modport master (
        output blk_valid, blk_first, blk_last, abort, digest_ready,
        input  blk_ready, sched_init, sched_index, round_en, wv_load,
               iv_sel, digest_update, digest_valid, busy
    );

    modport slave (
        input  blk_valid, blk_first, blk_last, abort, digest_ready,
        output blk_ready, sched_init, sched_index, round_en, wv_load,
               iv_sel, digest_update, digest_valid, busy
    );
endinterface

// File: rtl/sha256_round_controller_counter.sv
// Round/schedule-word counter: wraps to zero after the terminal count.
module sha256_round_counter
    import sha256_pkg::*;
#(
    parameter int unsigned WIDTH    = IDX_W,
    parameter int unsigned TERMINAL = NUM_ROUNDS - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign tc_o  = (cnt_q == WIDTH'(TERMINAL));
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/sha256_round_controller.sv
// Sequences one SHA-256 compression per accepted block: scheduler init, 64 rounds,
// digest accumulation, and final-digest handshake for the last block of a message.
module sha256_round_controller
    import sha256_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    sha256_round_controller_if.slave bus
);
    state_e           state_q, state_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             cnt_clr, cnt_en, cnt_tc;
    logic [IDX_W-1:0] cnt;

    // Counter is held at zero outside ROUND so every block starts at word 0.
    assign cnt_en  = (state_q == ST_ROUND);
    assign cnt_clr = bus.abort || (state_q != ST_ROUND);

    sha256_round_counter #(
        .WIDTH    (IDX_W),
        .TERMINAL (NUM_ROUNDS - 1)
    ) u_round_counter (
        .clk   (clk),
        .rst   (reset),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cnt),
        .tc_o  (cnt_tc)
    );

    assign bus.blk_ready = (state_q == ST_IDLE) && !bus.abort;

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        last_d  = last_q;
        if (bus.abort) begin
            state_d = ST_IDLE;
            first_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.blk_valid) begin
                        state_d = ST_LOAD;
                        first_d = bus.blk_first;
                        last_d  = bus.blk_last;
                    end
                end
                ST_LOAD:   state_d = ST_ROUND;
                ST_ROUND:  if (cnt_tc) state_d = ST_UPDATE;
                ST_UPDATE: state_d = last_q ? ST_DONE : ST_IDLE;
                ST_DONE:   if (bus.digest_ready) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Strobes decode only from registered state; index stays below SCHED_WORDS
    // outside ROUND so the scheduler neither shifts nor overrides init.
    always_comb begin
        bus.sched_init    = 1'b0;
        bus.sched_index   = '0;
        bus.round_en      = 1'b0;
        bus.wv_load       = 1'b0;
        bus.iv_sel        = 1'b0;
        bus.digest_update = 1'b0;
        bus.digest_valid  = 1'b0;
        bus.busy          = (state_q != ST_IDLE);
        unique case (state_q)
            ST_LOAD: begin
                bus.sched_init = 1'b1;
                bus.wv_load    = 1'b1;
                bus.iv_sel     = first_q;
            end
            ST_ROUND: begin
                bus.round_en    = 1'b1;
                bus.sched_index = cnt;
            end
            ST_UPDATE: bus.digest_update = 1'b1;
            ST_DONE:   bus.digest_valid  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end
endmodule
